// File: rtl/change_dispense_ctrl_if.sv
// Coin hopper handshake: one ejection request and coin code, acknowledged per coin.
interface change_dispense_ctrl_if;
   logic       eject_req;
   logic [2:0] eject_sel;
   logic       hopper_ack;

   modport master (output eject_req, output eject_sel, input hopper_ack);
   modport slave  (input eject_req, input eject_sel, output hopper_ack);
endinterface

// File: rtl/change_dispense_ctrl.sv
// Greedy change payout sequencer: drives one coin at a time through the hopper
// handshake, limited by an inventory snapshot, with a bounded wait on each ack.
module change_dispense_ctrl #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [7:0]            change_amount,
   input  logic [4:0]            nickelct,
   input  logic [4:0]            dimect,
   input  logic [4:0]            quarterct,
   input  logic [4:0]            half_dollarct,
   input  logic [4:0]            dollarct,
   change_dispense_ctrl_if.master hop,
   output logic                  busy,
   output logic                  done,
   output logic                  short,
   output logic                  fault,
   output logic [7:0]            remaining,
   output logic [4:0]            nickel_out,
   output logic [4:0]            dime_out,
   output logic [4:0]            quarter_out,
   output logic [4:0]            half_dollar_out,
   output logic [4:0]            dollar_out
);

   typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_GAP, S_DONE} state_t;

   // Index i holds denomination with coin code i+1 (nickel .. dollar).
   localparam logic [7:0] COIN_VAL [5] = '{8'd1, 8'd2, 8'd5, 8'd10, 8'd20};

   state_t     state_q, state_d;
   logic [7:0] remaining_q, remaining_d;
   logic [7:0] timer_q, timer_d;
   logic [4:0] inv_q [5];
   logic [4:0] inv_d [5];
   logic [4:0] paid_q [5];
   logic [4:0] paid_d [5];
   logic       eject_req_q, eject_req_d;
   logic [2:0] eject_sel_q, eject_sel_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       short_q, short_d;
   logic       fault_q, fault_d;

   logic [4:0] fits;
   logic       pick_found;
   logic [2:0] pick_idx;
   logic [2:0] sel_idx;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_fits
         assign fits[gi] = (inv_q[gi] != 5'd0) && (COIN_VAL[gi] <= remaining_q);
      end
   endgenerate

   // Ascending scan so the last qualifying (largest) denomination wins.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = 3'd0;
      for (int i = 0; i < 5; i++) begin
         if (fits[i]) begin
            pick_found = 1'b1;
            pick_idx   = 3'(i);
         end
      end
   end

   assign sel_idx = eject_sel_q - 3'd1;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      timer_d     = timer_q;
      inv_d       = inv_q;
      paid_d      = paid_q;
      short_d     = short_q;
      fault_d     = fault_q;
      eject_sel_d = 3'b000;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               remaining_d = change_amount;
               inv_d[0]    = nickelct;
               inv_d[1]    = dimect;
               inv_d[2]    = quarterct;
               inv_d[3]    = half_dollarct;
               inv_d[4]    = dollarct;
               for (int i = 0; i < 5; i++) paid_d[i] = 5'd0;
               short_d     = 1'b0;
               fault_d     = 1'b0;
               timer_d     = 8'd0;
               state_d     = S_SELECT;
            end
         end
         S_SELECT: begin
            if (remaining_q == 8'd0) begin
               state_d = S_DONE;
            end else if (pick_found) begin
               eject_sel_d = pick_idx + 3'd1;
               state_d     = S_ISSUE;
            end else begin
               short_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_ISSUE: begin
            eject_sel_d = eject_sel_q;
            if (hop.hopper_ack) begin
               remaining_d     = remaining_q - COIN_VAL[sel_idx];
               inv_d[sel_idx]  = inv_q[sel_idx] - 5'd1;
               paid_d[sel_idx] = paid_q[sel_idx] + 5'd1;
               timer_d         = 8'd0;
               eject_sel_d     = 3'b000;
               state_d         = S_GAP;
            end else if (timer_q == 8'(ACK_TIMEOUT - 1)) begin
               // Counter reaches ACK_TIMEOUT on this edge: give up on this coin.
               fault_d     = 1'b1;
               timer_d     = 8'd0;
               eject_sel_d = 3'b000;
               state_d     = S_DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         S_GAP:   state_d = S_SELECT;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      eject_req_d = (state_d == S_ISSUE);
      busy_d      = (state_d == S_SELECT) || (state_d == S_ISSUE) || (state_d == S_GAP);
      done_d      = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         remaining_q <= 8'd0;
         timer_q     <= 8'd0;
         for (int i = 0; i < 5; i++) begin
            inv_q[i]  <= 5'd0;
            paid_q[i] <= 5'd0;
         end
         eject_req_q <= 1'b0;
         eject_sel_q <= 3'b000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         short_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         inv_q       <= inv_d;
         paid_q      <= paid_d;
         eject_req_q <= eject_req_d;
         eject_sel_q <= eject_sel_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         short_q     <= short_d;
         fault_q     <= fault_d;
      end
   end

   assign hop.eject_req   = eject_req_q;
   assign hop.eject_sel   = eject_sel_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign short           = short_q;
   assign fault           = fault_q;
   assign remaining       = remaining_q;
   assign nickel_out      = paid_q[0];
   assign dime_out        = paid_q[1];
   assign quarter_out     = paid_q[2];
   assign half_dollar_out = paid_q[3];
   assign dollar_out      = paid_q[4];

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: hand-computed payouts, latencies,
// timeout, asynchronous reset and ignored start.
module tb_change_dispense_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] change_amount;
   logic [4:0] nickelct, dimect, quarterct, half_dollarct, dollarct;
   logic       busy, done, short, fault;
   logic [7:0] remaining;
   logic [4:0] nickel_out, dime_out, quarter_out, half_dollar_out, dollar_out;

   int total_cnt;
   int bad_cnt;

   change_dispense_ctrl_if hop ();

   change_dispense_ctrl #(.ACK_TIMEOUT(15)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .change_amount   (change_amount),
      .nickelct        (nickelct),
      .dimect          (dimect),
      .quarterct       (quarterct),
      .half_dollarct   (half_dollarct),
      .dollarct        (dollarct),
      .hop             (hop.master),
      .busy            (busy),
      .done            (done),
      .short           (short),
      .fault           (fault),
      .remaining       (remaining),
      .nickel_out      (nickel_out),
      .dime_out        (dime_out),
      .quarter_out     (quarter_out),
      .half_dollar_out (half_dollar_out),
      .dollar_out      (dollar_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ack_delay: 0 = ack tied high, 255 = never acked, else ack after that many request cycles.
   // inject_at: >0 raises start (amount 40) right after that edge, while busy.
   task automatic run_txn(input string tag, input logic [7:0] amt,
                          input logic [4:0] nc, input logic [4:0] dc, input logic [4:0] qc,
                          input logic [4:0] hc, input logic [4:0] dlc,
                          input int ack_delay, input int inject_at,
                          input int exp_edges, input int exp_req, input logic [7:0] exp_rem,
                          input logic exp_short, input logic exp_fault,
                          input logic [4:0] en, input logic [4:0] ed, input logic [4:0] eq,
                          input logic [4:0] eh, input logic [4:0] edl);
      int k;
      int req_cycles;
      int run;
      logic found;
      @(negedge clk);
      change_amount = amt;
      nickelct = nc; dimect = dc; quarterct = qc; half_dollarct = hc; dollarct = dlc;
      hop.hopper_ack = (ack_delay == 0);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq({tag, ".busy0"}, 32'(busy), 32'd1);
      k = 0; req_cycles = 0; run = 0; found = 1'b0;
      while (!found && k < 100) begin
         @(posedge clk);
         #1;
         k++;
         if (start) start = 1'b0;
         if (done) begin
            found = 1'b1;
         end else begin
            if (hop.eject_req) req_cycles++;
            if (ack_delay == 0) hop.hopper_ack = 1'b1;
            else if (ack_delay >= 255) hop.hopper_ack = 1'b0;
            else begin
               run = hop.eject_req ? run + 1 : 0;
               hop.hopper_ack = hop.eject_req && (run >= ack_delay);
            end
            if (k == inject_at) begin
               change_amount = 8'd40;
               start = 1'b1;
            end
         end
      end
      check_eq({tag, ".done_seen"}, 32'(found), 32'd1);
      check_eq({tag, ".done_edge"}, 32'(k), 32'(exp_edges));
      check_eq({tag, ".req_cycles"}, 32'(req_cycles), 32'(exp_req));
      check_eq({tag, ".remaining"}, 32'(remaining), 32'(exp_rem));
      check_eq({tag, ".short"}, 32'(short), 32'(exp_short));
      check_eq({tag, ".fault"}, 32'(fault), 32'(exp_fault));
      check_eq({tag, ".nickel"}, 32'(nickel_out), 32'(en));
      check_eq({tag, ".dime"}, 32'(dime_out), 32'(ed));
      check_eq({tag, ".quarter"}, 32'(quarter_out), 32'(eq));
      check_eq({tag, ".half"}, 32'(half_dollar_out), 32'(eh));
      check_eq({tag, ".dollar"}, 32'(dollar_out), 32'(edl));
      check_eq({tag, ".busy_at_done"}, 32'(busy), 32'd0);
      check_eq({tag, ".req_at_done"}, 32'(hop.eject_req), 32'd0);
      hop.hopper_ack = 1'b0;
      @(posedge clk);
      #1;
      check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
      check_eq({tag, ".short_held"}, 32'(short), 32'(exp_short));
      check_eq({tag, ".fault_held"}, 32'(fault), 32'(exp_fault));
      $display("txn %s amt=%0d edges=%0d req=%0d rem=%0d short=%0d fault=%0d", tag, amt, k,
               req_cycles, remaining, short, fault);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt = 0;
      rst = 1'b0;
      start = 1'b0;
      change_amount = 8'd0;
      nickelct = 5'd0; dimect = 5'd0; quarterct = 5'd0; half_dollarct = 5'd0; dollarct = 5'd0;
      hop.hopper_ack = 1'b0;
      #12;
      check_eq("rst.busy", 32'(busy), 32'd0);
      check_eq("rst.done", 32'(done), 32'd0);
      check_eq("rst.req", 32'(hop.eject_req), 32'd0);
      check_eq("rst.sel", 32'(hop.eject_sel), 32'd0);
      check_eq("rst.remaining", 32'(remaining), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      //       tag      amt  nc dc qc hc dl  ack inj edges req rem sh fl  n  d  q  h  dl
      run_txn("amt15",  15,  5, 5, 5, 5, 5,   0,  0,   7,   2,  0, 0, 0, 0, 0, 1, 1, 0);
      run_txn("amt0",    0,  5, 5, 5, 5, 5,   0,  0,   1,   0,  0, 0, 0, 0, 0, 0, 0, 0);
      run_txn("short3",  3,  0, 5, 5, 5, 5,   0,  0,   4,   1,  1, 1, 0, 0, 1, 0, 0, 0);
      run_txn("amt60",  60,  5, 5, 5, 5, 2,   0,  0,  13,   4,  0, 0, 0, 0, 0, 0, 2, 2);
      run_txn("amt9",    9,  5, 5, 5, 5, 5,   0,  0,  10,   3,  0, 0, 0, 0, 2, 1, 0, 0);
      run_txn("delay3",  1,  5, 5, 5, 5, 5,   3,  0,   6,   3,  0, 0, 0, 1, 0, 0, 0, 0);
      run_txn("tmo",     7,  5, 5, 5, 5, 5, 255,  0,  16,  15,  7, 0, 1, 0, 0, 0, 0, 0);

      // Asynchronous reset while a coin request is outstanding.
      @(negedge clk);
      change_amount = 8'd15;
      nickelct = 5'd5; dimect = 5'd5; quarterct = 5'd5; half_dollarct = 5'd5; dollarct = 5'd5;
      hop.hopper_ack = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check_eq("arst.req_before", 32'(hop.eject_req), 32'd1);
      check_eq("arst.sel_before", 32'(hop.eject_sel), 32'd4);
      #2;
      rst = 1'b0;
      #1;
      check_eq("arst.req", 32'(hop.eject_req), 32'd0);
      check_eq("arst.sel", 32'(hop.eject_sel), 32'd0);
      check_eq("arst.busy", 32'(busy), 32'd0);
      check_eq("arst.remaining", 32'(remaining), 32'd0);
      $display("txn arst req=%0d sel=%0d busy=%0d rem=%0d", hop.eject_req, hop.eject_sel, busy,
               remaining);
      @(negedge clk);
      rst = 1'b1;

      run_txn("ignstart", 15, 5, 5, 5, 5, 5,   0,  2,   7,   2,  0, 0, 0, 0, 0, 1, 1, 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
